// File: rtl/tree_node_writer_if.sv
// Handshake bundle for tree_node_writer: insert command, allocator request, node RAM port, completion.
// The slave modport is the writer's view; master is the environment's view.
interface tree_node_writer_if #(
    parameter int unsigned RAM_ADDR_WIDTH = 16,
    parameter int unsigned TOKEN_WIDTH    = 8,
    parameter int unsigned PAYLOAD_WIDTH  = 32
);
    localparam int unsigned AW = RAM_ADDR_WIDTH;
    localparam int unsigned DW = TOKEN_WIDTH + PAYLOAD_WIDTH + 2 * AW;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [TOKEN_WIDTH-1:0]   cmd_token;
    logic [PAYLOAD_WIDTH-1:0] cmd_payload;
    logic [AW-1:0]            cmd_parent_addr;
    logic                     cmd_side;
    logic                     cmd_is_root;

    logic                     tree_mgt_req_valid;
    logic                     tree_mgt_req_ready;
    logic [AW-1:0]            tree_mgt_req_addr;
    logic                     tree_mgt_full;

    logic                     ram_en;
    logic                     ram_wr;
    logic [AW-1:0]            ram_addr;
    logic [DW-1:0]            ram_wr_data;
    logic [DW-1:0]            ram_rd_data;

    logic                     done_valid;
    logic                     done_ready;
    logic [AW-1:0]            done_addr;
    logic [1:0]               done_status;

    modport slave (
        input  cmd_valid, cmd_token, cmd_payload, cmd_parent_addr, cmd_side, cmd_is_root,
        output cmd_ready,
        output tree_mgt_req_valid,
        input  tree_mgt_req_ready, tree_mgt_req_addr, tree_mgt_full,
        output ram_en, ram_wr, ram_addr, ram_wr_data,
        input  ram_rd_data,
        output done_valid, done_addr, done_status,
        input  done_ready
    );

    modport master (
        output cmd_valid, cmd_token, cmd_payload, cmd_parent_addr, cmd_side, cmd_is_root,
        input  cmd_ready,
        input  tree_mgt_req_valid,
        output tree_mgt_req_ready, tree_mgt_req_addr, tree_mgt_full,
        input  ram_en, ram_wr, ram_addr, ram_wr_data,
        output ram_rd_data,
        input  done_valid, done_addr, done_status,
        output done_ready
    );
endinterface

// File: rtl/tree_node_writer.sv
// Inserts one tree node: allocates an address, writes the node, links it into its parent.
// Optional macro TREE_NODE_WRITER_COLLISION_CHECK_EN refuses to overwrite an occupied child slot.
module tree_node_writer #(
    parameter int unsigned RAM_ADDR_WIDTH = 16,
    parameter int unsigned TOKEN_WIDTH    = 8,
    parameter int unsigned PAYLOAD_WIDTH  = 32
) (
    input logic               aclk,
    input logic               aresetn,
    tree_node_writer_if.slave bus
);
    localparam int unsigned   AW        = RAM_ADDR_WIDTH;
    localparam int unsigned   DW        = TOKEN_WIDTH + PAYLOAD_WIDTH + 2 * AW;
    localparam logic [AW-1:0] NULL_PTR  = {AW{1'b1}};
    localparam logic [1:0]    STAT_OK   = 2'b00;
    localparam logic [1:0]    STAT_FULL = 2'b01;
`ifdef TREE_NODE_WRITER_COLLISION_CHECK_EN
    localparam logic [1:0]    STAT_COLL = 2'b10;
`endif

    typedef enum logic [2:0] {
        StIdle, StRdParent, StWaitRd, StReq, StWrNode, StWrParent, StDone
    } state_e;

    state_e                   r_state;
    state_e                   w_next;
    logic                     r_out_en;
    logic [TOKEN_WIDTH-1:0]   r_token;
    logic [PAYLOAD_WIDTH-1:0] r_payload;
    logic [AW-1:0]            r_parent_addr;
    logic                     r_side;
    logic                     r_is_root;
    logic [DW-1:0]            r_parent_word;
    logic [AW-1:0]            r_node_addr;
    logic [AW-1:0]            r_done_addr;
    logic [1:0]               r_status;

    logic                     w_cmd_fire;
    logic                     w_grant;
    logic                     w_set_done;
    logic [AW-1:0]            w_done_addr_d;
    logic [1:0]               w_status_d;
    logic [DW-1:0]            w_parent_upd;
`ifdef TREE_NODE_WRITER_COLLISION_CHECK_EN
    logic [AW-1:0]            w_child;

    assign w_child = r_side ? bus.ram_rd_data[AW-1:0] : bus.ram_rd_data[2*AW-1:AW];
`endif

    assign w_cmd_fire   = (r_state == StIdle) && r_out_en && bus.cmd_valid;
    assign w_grant      = (r_state == StReq) && bus.tree_mgt_req_ready;
    // Only the pointer on the insertion side changes; token, payload and sibling are kept.
    assign w_parent_upd = r_side ? {r_parent_word[DW-1:AW], r_node_addr}
                                 : {r_parent_word[DW-1:2*AW], r_node_addr, r_parent_word[AW-1:0]};
    assign bus.done_addr   = r_done_addr;
    assign bus.done_status = r_status;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= StIdle;
            r_out_en      <= 1'b0;
            r_token       <= '0;
            r_payload     <= '0;
            r_parent_addr <= '0;
            r_side        <= 1'b0;
            r_is_root     <= 1'b0;
            r_parent_word <= '0;
            r_node_addr   <= '0;
            r_done_addr   <= '0;
            r_status      <= STAT_OK;
        end else begin
            r_state  <= w_next;
            r_out_en <= 1'b1;
            if (w_cmd_fire) begin
                r_token       <= bus.cmd_token;
                r_payload     <= bus.cmd_payload;
                r_parent_addr <= bus.cmd_parent_addr;
                r_side        <= bus.cmd_side;
                r_is_root     <= bus.cmd_is_root;
            end
            if (r_state == StWaitRd) r_parent_word <= bus.ram_rd_data;
            if (w_grant)             r_node_addr   <= bus.tree_mgt_req_addr;
            if (w_set_done) begin
                r_done_addr <= w_done_addr_d;
                r_status    <= w_status_d;
            end
        end
    end

    always_comb begin
        w_next                 = r_state;
        w_set_done             = 1'b0;
        w_done_addr_d          = r_node_addr;
        w_status_d             = STAT_OK;
        bus.cmd_ready          = 1'b0;
        bus.tree_mgt_req_valid = 1'b0;
        bus.ram_en             = 1'b0;
        bus.ram_wr             = 1'b0;
        bus.ram_addr           = '0;
        bus.ram_wr_data        = '0;
        bus.done_valid         = 1'b0;
        unique case (r_state)
            StIdle: begin
                bus.cmd_ready = r_out_en;
                if (w_cmd_fire) w_next = bus.cmd_is_root ? StReq : StRdParent;
            end
            StRdParent: begin
                bus.ram_en   = 1'b1;
                bus.ram_addr = r_parent_addr;
                w_next       = StWaitRd;
            end
            StWaitRd: begin
                w_next = StReq;
`ifdef TREE_NODE_WRITER_COLLISION_CHECK_EN
                if (w_child != NULL_PTR) begin
                    w_next        = StDone;
                    w_set_done    = 1'b1;
                    w_done_addr_d = w_child;
                    w_status_d    = STAT_COLL;
                end
`endif
            end
            StReq: begin
                bus.tree_mgt_req_valid = 1'b1;
                if (bus.tree_mgt_req_ready) begin
                    w_next = StWrNode;
                end else if (bus.tree_mgt_full) begin
                    w_next        = StDone;
                    w_set_done    = 1'b1;
                    w_done_addr_d = NULL_PTR;
                    w_status_d    = STAT_FULL;
                end
            end
            StWrNode: begin
                bus.ram_en      = 1'b1;
                bus.ram_wr      = 1'b1;
                bus.ram_addr    = r_node_addr;
                bus.ram_wr_data = {r_token, r_payload, NULL_PTR, NULL_PTR};
                w_next          = r_is_root ? StDone : StWrParent;
                w_set_done      = r_is_root;
            end
            StWrParent: begin
                bus.ram_en      = 1'b1;
                bus.ram_wr      = 1'b1;
                bus.ram_addr    = r_parent_addr;
                bus.ram_wr_data = w_parent_upd;
                w_next          = StDone;
                w_set_done      = 1'b1;
            end
            StDone: begin
                bus.done_valid = 1'b1;
                if (bus.done_ready) w_next = StIdle;
            end
            default: w_next = StIdle;
        endcase
    end
endmodule

// File: tb/tb_tree_node_writer.sv
// Randomized bench for tree_node_writer: behavioural RAM, allocator and reference tree model.
// Build with or without TREE_NODE_WRITER_COLLISION_CHECK_EN; the model follows the same macro.
module tb_tree_node_writer;
    localparam int unsigned   AW = 16;
    localparam int unsigned   TW = 8;
    localparam int unsigned   PW = 32;
    localparam int unsigned   DW = TW + PW + 2 * AW;
    localparam logic [AW-1:0] NULL_PTR = {AW{1'b1}};
`ifdef TREE_NODE_WRITER_COLLISION_CHECK_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif

    typedef logic [DW-1:0] word_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    tree_node_writer_if #(
        .RAM_ADDR_WIDTH(AW), .TOKEN_WIDTH(TW), .PAYLOAD_WIDTH(PW)
    ) bus ();

    tree_node_writer #(
        .RAM_ADDR_WIDTH(AW), .TOKEN_WIDTH(TW), .PAYLOAD_WIDTH(PW)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Environment: node RAM with a preload port, allocator, completion sink, bus monitor.
    word_t         tb_ram [16];
    word_t         ref_mem[16];
    logic          ld_en = 1'b0;
    logic [3:0]    ld_idx = '0;
    word_t         ld_data = '0;
    logic [AW-1:0] mon_wr_addr[$];
    word_t         mon_wr_data[$];
    int            mon_rd = 0;
    int            mon_req = 0;
    int            g_delay = 0;
    bit            g_full = 1'b0;
    logic [AW-1:0] g_addr = '0;
    int            d_delay = 0;
    int            gcnt = 0;
    int            dcnt = 0;

    always @(posedge aclk) begin
        if (ld_en) tb_ram[ld_idx] <= ld_data;
        else if (bus.ram_en) begin
            if (bus.ram_wr) tb_ram[bus.ram_addr[3:0]] <= bus.ram_wr_data;
            else            bus.ram_rd_data <= tb_ram[bus.ram_addr[3:0]];
        end
    end

    always @(posedge aclk) begin
        if (aresetn && bus.ram_en && bus.ram_wr) begin
            mon_wr_addr.push_back(bus.ram_addr);
            mon_wr_data.push_back(bus.ram_wr_data);
        end
        if (aresetn && bus.ram_en && !bus.ram_wr) mon_rd <= mon_rd + 1;
        if (aresetn && bus.tree_mgt_req_valid)    mon_req <= mon_req + 1;
    end

    always @(negedge aclk) begin
        bus.tree_mgt_full     = g_full;
        bus.tree_mgt_req_addr = g_addr;
        if (aresetn && bus.tree_mgt_req_valid) begin
            bus.tree_mgt_req_ready = !g_full && (gcnt >= g_delay);
            gcnt++;
        end else begin
            bus.tree_mgt_req_ready = 1'b0;
            gcnt = 0;
        end
        if (aresetn && bus.done_valid) begin
            bus.done_ready = (dcnt >= d_delay);
            dcnt++;
        end else begin
            bus.done_ready = 1'b0;
            dcnt = 0;
        end
    end

    task automatic preload(input bit rand_children);
        for (int i = 0; i < 16; i++) begin
            logic [AW-1:0] l, r;
            word_t w;
            l = (rand_children && ($urandom % 3 != 0)) ? AW'($urandom % 16) : NULL_PTR;
            r = (rand_children && ($urandom % 3 != 0)) ? AW'($urandom % 16) : NULL_PTR;
            w = {TW'($urandom), PW'($urandom), l, r};
            @(negedge aclk);
            ld_en = 1'b1; ld_idx = 4'(i); ld_data = w;
            ref_mem[i] = w;
        end
        @(negedge aclk);
        ld_en = 1'b0;
    endtask

    task automatic run_cmd(input bit root, input logic [AW-1:0] paddr, input bit side,
                           input logic [TW-1:0] tok, input logic [PW-1:0] pay,
                           input logic [AW-1:0] gaddr, input bit full, input int gdly,
                           input int ddly);
        logic [AW-1:0] e_wa[$];
        word_t         e_wd[$];
        word_t         p, node;
        logic [AW-1:0] child, e_addr;
        logic [1:0]    e_stat;
        int            e_lat, e_req, wr0, rd0, req0, n, k;
        bit            coll;
        // Reference: what the tree should look like after this insert.
        p     = ref_mem[paddr[3:0]];
        child = side ? p[AW-1:0] : p[2*AW-1:AW];
        node  = {tok, pay, NULL_PTR, NULL_PTR};
        coll  = !root && COLL && (child != NULL_PTR);
        e_req = coll ? 0 : 1;
        if (coll) begin
            e_stat = 2'b10; e_addr = child; e_lat = 3;
        end else if (full) begin
            e_stat = 2'b01; e_addr = NULL_PTR; e_lat = root ? 2 : 4;
        end else begin
            e_stat = 2'b00; e_addr = gaddr; e_lat = root ? 3 + gdly : 6 + gdly;
            e_wa.push_back(gaddr); e_wd.push_back(node);
            ref_mem[gaddr[3:0]] = node;
            if (!root) begin
                if (side) p[AW-1:0] = gaddr;
                else      p[2*AW-1:AW] = gaddr;
                e_wa.push_back(paddr); e_wd.push_back(p);
                ref_mem[paddr[3:0]] = p;
            end
        end

        @(negedge aclk);
        g_delay = gdly; g_full = full; g_addr = gaddr; d_delay = ddly;
        wr0 = mon_wr_addr.size(); rd0 = mon_rd; req0 = mon_req;
        bus.cmd_valid = 1'b1; bus.cmd_is_root = root; bus.cmd_parent_addr = paddr;
        bus.cmd_side = side; bus.cmd_token = tok; bus.cmd_payload = pay;
        k = 0;
        while (!bus.cmd_ready && k < 20) begin
            @(negedge aclk);
            k++;
        end
        check("cmd_accept", word_t'(bus.cmd_ready), word_t'(1));
        @(posedge aclk);
        @(negedge aclk);
        bus.cmd_valid = 1'b0;
        n = 1;
        while (!bus.done_valid && n < 80) begin
            @(negedge aclk);
            n++;
        end
        check("done_valid", word_t'(bus.done_valid), word_t'(1));
        check("done_latency", word_t'(n), word_t'(e_lat));
        check("done_addr", word_t'(bus.done_addr), word_t'(e_addr));
        check("done_status", word_t'(bus.done_status), word_t'(e_stat));
        for (int i = 0; i < ddly; i++) begin
            @(negedge aclk);
            check("stall_valid", word_t'(bus.done_valid), word_t'(1));
            check("stall_addr", word_t'(bus.done_addr), word_t'(e_addr));
            check("stall_status", word_t'(bus.done_status), word_t'(e_stat));
            check("stall_cmd_ready", word_t'(bus.cmd_ready), word_t'(0));
        end
        @(negedge aclk);
        check("idle_done_valid", word_t'(bus.done_valid), word_t'(0));
        check("idle_cmd_ready", word_t'(bus.cmd_ready), word_t'(1));
        check("n_writes", word_t'(mon_wr_addr.size() - wr0), word_t'(e_wa.size()));
        check("n_reads", word_t'(mon_rd - rd0), word_t'(root ? 0 : 1));
        check("req_seen", word_t'(mon_req > req0), word_t'(e_req));
        for (int i = 0; i < e_wa.size() && wr0 + i < mon_wr_addr.size(); i++) begin
            check("wr_addr", word_t'(mon_wr_addr[wr0 + i]), word_t'(e_wa[i]));
            check("wr_data", mon_wr_data[wr0 + i], e_wd[i]);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_cmd_ready", word_t'(bus.cmd_ready), word_t'(0));
        check("rst_req_valid", word_t'(bus.tree_mgt_req_valid), word_t'(0));
        check("rst_ram_en", word_t'(bus.ram_en), word_t'(0));
        check("rst_ram_wr", word_t'(bus.ram_wr), word_t'(0));
        check("rst_ram_addr", word_t'(bus.ram_addr), word_t'(0));
        check("rst_ram_wr_data", bus.ram_wr_data, word_t'(0));
        check("rst_done_valid", word_t'(bus.done_valid), word_t'(0));
        check("rst_done_addr", word_t'(bus.done_addr), word_t'(0));
        check("rst_done_status", word_t'(bus.done_status), word_t'(0));
    endtask

    initial begin
        int k, wr0;
        bus.cmd_valid = 1'b0; bus.cmd_token = '0; bus.cmd_payload = '0;
        bus.cmd_parent_addr = '0; bus.cmd_side = 1'b0; bus.cmd_is_root = 1'b0;
        repeat (3) @(negedge aclk);
        check_reset_outputs();
        aresetn = 1'b1;
        preload(1'b0);

        // Directed: root, left child, full, done back-pressure, second left insert, right insert.
        run_cmd(1'b1, 16'h0000, 1'b0, 8'h05, 32'h0000_1234, 16'h0000, 1'b0, 0, 0);
        run_cmd(1'b0, 16'h0000, 1'b0, 8'h11, 32'hCAFE_0001, 16'h0001, 1'b0, 0, 0);
        run_cmd(1'b1, 16'h0000, 1'b0, 8'h22, 32'h0000_0022, 16'h0002, 1'b1, 0, 0);
        run_cmd(1'b1, 16'h0000, 1'b0, 8'h33, 32'h0000_0033, 16'h0002, 1'b0, 0, 5);
        run_cmd(1'b0, 16'h0000, 1'b0, 8'h44, 32'h0000_0044, 16'h0003, 1'b0, 0, 0);
        run_cmd(1'b0, 16'h0001, 1'b1, 8'h55, 32'h0000_0055, 16'h0004, 1'b0, 1, 1);

        preload(1'b1);
        for (int i = 0; i < 40; i++) begin
            run_cmd(($urandom % 4) == 0, AW'($urandom % 16), 1'($urandom),
                    TW'($urandom), PW'($urandom), AW'($urandom % 16),
                    ($urandom % 6) == 0, int'($urandom % 3), int'($urandom % 3));
        end

        // Reset while the node write is on the bus: it must vanish immediately.
        @(negedge aclk);
        g_delay = 0; g_full = 1'b0; g_addr = 16'h0005; d_delay = 0;
        bus.cmd_valid = 1'b1; bus.cmd_is_root = 1'b1; bus.cmd_token = 8'h66;
        bus.cmd_payload = 32'h0000_0066;
        k = 0;
        while (!bus.cmd_ready && k < 20) begin
            @(negedge aclk);
            k++;
        end
        @(posedge aclk);
        @(negedge aclk);
        bus.cmd_valid = 1'b0;
        k = 0;
        while (!(bus.ram_en && bus.ram_wr) && k < 20) begin
            @(negedge aclk);
            k++;
        end
        check("reached_wr_node", word_t'(bus.ram_wr), word_t'(1));
        wr0 = mon_wr_addr.size();
        #1 aresetn = 1'b0;
        #1 check_reset_outputs();
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        check("post_rst_cmd_ready", word_t'(bus.cmd_ready), word_t'(1));
        check("post_rst_no_write", word_t'(mon_wr_addr.size() - wr0), word_t'(0));
        check("post_rst_done_valid", word_t'(bus.done_valid), word_t'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
